mem_port_arbiter: RTL and testbench

Arbitrates between the IF-stage instruction fetch port and the MEM-stage data port for a single-ported, unified, synchronous-read memory. Holds the read-return ownership for one cycle so each read result is routed back to its issuing stage. A bounded-wait counter keeps a continuous stream of loads and stores from starving instruction fetch. It sits between `if_stage`/`mem_stage` and the shared memory macro, and exports a fetch stall for the pipeline register control.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port, memory-macro port and status outputs of mem_port_arbiter.
// The master modport is the pipeline/memory side; the slave modport is the arbiter.
interface mem_port_arbiter_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;

  logic        D_REQ;
  logic        D_WE;
  logic [1:0]  D_SIZE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;

  logic        M_EN;
  logic        M_WE;
  logic [1:0]  M_SIZE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [31:0] M_RDATA;

  logic        STALL_IF;
  logic [31:0] CONFLICT_CNT;

  modport master (
    output I_REQ, I_ADDR,
    input  I_GNT, I_RVALID, I_RDATA,
    output D_REQ, D_WE, D_SIZE, D_ADDR, D_WDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  M_EN, M_WE, M_SIZE, M_ADDR, M_WDATA,
    output M_RDATA,
    input  STALL_IF, CONFLICT_CNT
  );

  modport slave (
    input  I_REQ, I_ADDR,
    output I_GNT, I_RVALID, I_RDATA,
    input  D_REQ, D_WE, D_SIZE, D_ADDR, D_WDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output M_EN, M_WE, M_SIZE, M_ADDR, M_WDATA,
    input  M_RDATA,
    output STALL_IF, CONFLICT_CNT
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported synchronous-read memory, with bounded fetch starvation
// and a one-cycle read-return owner so each read result goes back to the stage that issued it.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input logic              CLK,
  input logic              RST,
  mem_port_arbiter_if.slave bus
);

  localparam int WAIT_W = (MAX_WAIT < 8) ? 3 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       conflict_cnt_q, conflict_cnt_d;
  logic              conflict;
  logic              i_gnt;
  logic              d_gnt;

  assign conflict = bus.I_REQ & bus.D_REQ;

  // Data wins a conflict until fetch has lost MAX_WAIT in a row; nothing is granted in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RST) begin
      if (conflict) begin
        if (wait_cnt_q < WAIT_MAX) begin
          d_gnt = 1'b1;
        end else begin
          i_gnt = 1'b1;
        end
      end else if (bus.I_REQ) begin
        i_gnt = 1'b1;
      end else if (bus.D_REQ) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d     = '0;
    rd_owner_d     = OWN_NONE;
    conflict_cnt_d = conflict_cnt_q;

    if (conflict && d_gnt) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (i_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (d_gnt && !bus.D_WE) begin
      rd_owner_d = OWN_MEM;
    end

    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q     <= '0;
      rd_owner_q     <= OWN_NONE;
      conflict_cnt_q <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      rd_owner_q     <= rd_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // A return still in flight when reset arrives is masked rather than delivered.
  always_comb begin
    bus.I_GNT        = i_gnt;
    bus.D_GNT        = d_gnt;
    bus.STALL_IF     = bus.I_REQ & ~i_gnt;
    bus.CONFLICT_CNT = conflict_cnt_q;

    bus.M_EN    = 1'b0;
    bus.M_WE    = 1'b0;
    bus.M_SIZE  = 2'b00;
    bus.M_ADDR  = '0;
    bus.M_WDATA = '0;
    if (i_gnt) begin
      bus.M_EN   = 1'b1;
      bus.M_SIZE = 2'b10;
      bus.M_ADDR = bus.I_ADDR;
    end else if (d_gnt) begin
      bus.M_EN    = 1'b1;
      bus.M_WE    = bus.D_WE;
      bus.M_SIZE  = bus.D_SIZE;
      bus.M_ADDR  = bus.D_ADDR;
      bus.M_WDATA = bus.D_WDATA;
    end

    bus.I_RVALID = (rd_owner_q == OWN_IF) && !RST;
    bus.D_RVALID = (rd_owner_q == OWN_MEM) && !RST;
    bus.I_RDATA  = bus.I_RVALID ? bus.M_RDATA : 32'd0;
    bus.D_RDATA  = bus.D_RVALID ? bus.M_RDATA : 32'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MAX_WAIT=4 and one with MAX_WAIT=0.
module tb_mem_port_arbiter;

  logic CLK;
  logic RST;
  int   chk_cnt;
  int   pass_cnt;

  mem_port_arbiter_if bus4 ();
  mem_port_arbiter_if bus0 ();

  mem_port_arbiter #(.MAX_WAIT(4)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4)
  );

  mem_port_arbiter #(.MAX_WAIT(0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.I_REQ = 1'b0; bus4.I_ADDR = '0; bus4.D_REQ = 1'b0; bus4.D_WE = 1'b0;
    bus4.D_SIZE = 2'b00; bus4.D_ADDR = '0; bus4.D_WDATA = '0; bus4.M_RDATA = '0;
    bus0.I_REQ = 1'b0; bus0.I_ADDR = '0; bus0.D_REQ = 1'b0; bus0.D_WE = 1'b0;
    bus0.D_SIZE = 2'b00; bus0.D_ADDR = '0; bus0.D_WDATA = '0; bus0.M_RDATA = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    bus4.I_REQ = 1'b1;
    bus4.D_REQ = 1'b1;
    tick();
    tick();
    #1;
    chk_cnt++; if (bus4.I_GNT !== 1'b0) $display("[TB] FAIL reset_i_gnt: got %b expected 0", bus4.I_GNT); else pass_cnt++;
    chk_cnt++; if (bus4.D_GNT !== 1'b0) $display("[TB] FAIL reset_d_gnt: got %b expected 0", bus4.D_GNT); else pass_cnt++;
    chk_cnt++; if (bus4.M_EN !== 1'b0) $display("[TB] FAIL reset_m_en: got %b expected 0", bus4.M_EN); else pass_cnt++;
    chk_cnt++; if (bus4.STALL_IF !== 1'b1) $display("[TB] FAIL reset_stall_if: got %b expected 1", bus4.STALL_IF); else pass_cnt++;
    chk_cnt++; if (bus4.I_RVALID !== 1'b0 || bus4.D_RVALID !== 1'b0)
      $display("[TB] FAIL reset_rvalid: got i=%b d=%b expected 0 0", bus4.I_RVALID, bus4.D_RVALID); else pass_cnt++;
    chk_cnt++; if (bus4.I_RDATA !== 32'd0 || bus4.D_RDATA !== 32'd0)
      $display("[TB] FAIL reset_rdata: got i=%h d=%h expected 0 0", bus4.I_RDATA, bus4.D_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.CONFLICT_CNT !== 32'd0) $display("[TB] FAIL reset_conflict_cnt: got %0d expected 0", bus4.CONFLICT_CNT); else pass_cnt++;
    RST = 1'b0;
    bus4.I_REQ = 1'b0;
    bus4.D_REQ = 1'b0;
  endtask

  task automatic test_fetch_only();
    tick();
    bus4.I_REQ  = 1'b1;
    bus4.I_ADDR = 32'h0000_0010;
    #1;
    chk_cnt++; if (bus4.I_GNT !== 1'b1) $display("[TB] FAIL fetch_i_gnt: got %b expected 1", bus4.I_GNT); else pass_cnt++;
    chk_cnt++; if (bus4.M_EN !== 1'b1 || bus4.M_WE !== 1'b0)
      $display("[TB] FAIL fetch_m_en_we: got en=%b we=%b expected 1 0", bus4.M_EN, bus4.M_WE); else pass_cnt++;
    chk_cnt++; if (bus4.M_ADDR !== 32'h0000_0010) $display("[TB] FAIL fetch_m_addr: got %h expected 00000010", bus4.M_ADDR); else pass_cnt++;
    chk_cnt++; if (bus4.M_SIZE !== 2'b10) $display("[TB] FAIL fetch_m_size: got %b expected 10", bus4.M_SIZE); else pass_cnt++;
    chk_cnt++; if (bus4.STALL_IF !== 1'b0) $display("[TB] FAIL fetch_stall_if: got %b expected 0", bus4.STALL_IF); else pass_cnt++;
    chk_cnt++; if (bus4.D_RVALID !== 1'b0) $display("[TB] FAIL fetch_d_rvalid_c0: got %b expected 0", bus4.D_RVALID); else pass_cnt++;
    tick();
    bus4.I_REQ   = 1'b0;
    bus4.M_RDATA = 32'h0000_0013;
    #1;
    chk_cnt++; if (bus4.I_RVALID !== 1'b1) $display("[TB] FAIL fetch_i_rvalid: got %b expected 1", bus4.I_RVALID); else pass_cnt++;
    chk_cnt++; if (bus4.I_RDATA !== 32'h0000_0013) $display("[TB] FAIL fetch_i_rdata: got %h expected 00000013", bus4.I_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.D_RVALID !== 1'b0 || bus4.D_RDATA !== 32'd0)
      $display("[TB] FAIL fetch_d_side_c1: got v=%b d=%h expected 0 0", bus4.D_RVALID, bus4.D_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.M_EN !== 1'b0) $display("[TB] FAIL fetch_idle_m_en: got %b expected 0", bus4.M_EN); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (bus4.I_RVALID !== 1'b0) $display("[TB] FAIL fetch_i_rvalid_c2: got %b expected 0", bus4.I_RVALID); else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic [5:0] exp_i;
    exp_i = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        bus4.I_REQ  = 1'b1;
        bus4.I_ADDR = 32'h0000_0100;
        bus4.D_REQ  = 1'b1;
        bus4.D_WE   = 1'b0;
        bus4.D_SIZE = 2'b01;
        bus4.D_ADDR = 32'h0000_0200;
      end
      #1;
      chk_cnt++; if (bus4.I_GNT !== exp_i[k] || bus4.D_GNT !== ~exp_i[k])
        $display("[TB] FAIL conflict_grant c%0d: got i=%b d=%b expected i=%b d=%b", k, bus4.I_GNT, bus4.D_GNT, exp_i[k], ~exp_i[k]); else pass_cnt++;
      chk_cnt++; if (bus4.STALL_IF !== ~exp_i[k])
        $display("[TB] FAIL conflict_stall c%0d: got %b expected %b", k, bus4.STALL_IF, ~exp_i[k]); else pass_cnt++;
      chk_cnt++; if (bus4.M_SIZE !== (exp_i[k] ? 2'b10 : 2'b01))
        $display("[TB] FAIL conflict_m_size c%0d: got %b expected %b", k, bus4.M_SIZE, exp_i[k] ? 2'b10 : 2'b01); else pass_cnt++;
    end
    tick();
    bus4.I_REQ = 1'b0;
    bus4.D_REQ = 1'b0;
    #1;
    chk_cnt++; if (bus4.CONFLICT_CNT !== 32'd6) $display("[TB] FAIL conflict_cnt: got %0d expected 6", bus4.CONFLICT_CNT); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick();
    bus4.D_REQ  = 1'b1;
    bus4.D_WE   = 1'b0;
    bus4.D_SIZE = 2'b10;
    bus4.D_ADDR = 32'h0010_0000;
    #1;
    chk_cnt++; if (bus4.D_GNT !== 1'b1 || bus4.M_ADDR !== 32'h0010_0000)
      $display("[TB] FAIL b2b_d_grant: got gnt=%b addr=%h expected 1 00100000", bus4.D_GNT, bus4.M_ADDR); else pass_cnt++;
    tick();
    bus4.D_REQ   = 1'b0;
    bus4.I_REQ   = 1'b1;
    bus4.I_ADDR  = 32'h0000_0004;
    bus4.M_RDATA = 32'hAAAA_AAAA;
    #1;
    chk_cnt++; if (bus4.D_RVALID !== 1'b1 || bus4.D_RDATA !== 32'hAAAA_AAAA)
      $display("[TB] FAIL b2b_d_return: got v=%b d=%h expected 1 aaaaaaaa", bus4.D_RVALID, bus4.D_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.I_RVALID !== 1'b0 || bus4.I_RDATA !== 32'd0)
      $display("[TB] FAIL b2b_i_quiet_c1: got v=%b d=%h expected 0 0", bus4.I_RVALID, bus4.I_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.I_GNT !== 1'b1 || bus4.M_ADDR !== 32'h0000_0004)
      $display("[TB] FAIL b2b_i_grant: got gnt=%b addr=%h expected 1 00000004", bus4.I_GNT, bus4.M_ADDR); else pass_cnt++;
    tick();
    bus4.I_REQ   = 1'b0;
    bus4.M_RDATA = 32'hBBBB_BBBB;
    #1;
    chk_cnt++; if (bus4.I_RVALID !== 1'b1 || bus4.I_RDATA !== 32'hBBBB_BBBB)
      $display("[TB] FAIL b2b_i_return: got v=%b d=%h expected 1 bbbbbbbb", bus4.I_RVALID, bus4.I_RDATA); else pass_cnt++;
    chk_cnt++; if (bus4.D_RVALID !== 1'b0 || bus4.D_RDATA !== 32'd0)
      $display("[TB] FAIL b2b_d_quiet_c2: got v=%b d=%h expected 0 0", bus4.D_RVALID, bus4.D_RDATA); else pass_cnt++;
  endtask

  task automatic test_store();
    tick();
    bus4.D_REQ   = 1'b1;
    bus4.D_WE    = 1'b1;
    bus4.D_SIZE  = 2'b00;
    bus4.D_ADDR  = 32'h0000_0020;
    bus4.D_WDATA = 32'h0000_005A;
    #1;
    chk_cnt++; if (bus4.D_GNT !== 1'b1 || bus4.M_EN !== 1'b1 || bus4.M_WE !== 1'b1)
      $display("[TB] FAIL store_grant: got gnt=%b en=%b we=%b expected 1 1 1", bus4.D_GNT, bus4.M_EN, bus4.M_WE); else pass_cnt++;
    chk_cnt++; if (bus4.M_SIZE !== 2'b00 || bus4.M_WDATA !== 32'h0000_005A)
      $display("[TB] FAIL store_payload: got size=%b wdata=%h expected 00 0000005a", bus4.M_SIZE, bus4.M_WDATA); else pass_cnt++;
    tick();
    bus4.D_REQ   = 1'b0;
    bus4.D_WE    = 1'b0;
    bus4.M_RDATA = 32'hDEAD_BEEF;
    #1;
    chk_cnt++; if (bus4.D_RVALID !== 1'b0 || bus4.D_RDATA !== 32'd0)
      $display("[TB] FAIL store_no_return: got v=%b d=%h expected 0 0", bus4.D_RVALID, bus4.D_RDATA); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    tick();
    bus4.I_REQ  = 1'b1;
    bus4.I_ADDR = 32'h0000_0008;
    #1;
    chk_cnt++; if (bus4.I_GNT !== 1'b1) $display("[TB] FAIL midrst_grant: got %b expected 1", bus4.I_GNT); else pass_cnt++;
    tick();
    RST          = 1'b1;
    bus4.I_REQ   = 1'b0;
    bus4.M_RDATA = 32'h0000_0077;
    #1;
    chk_cnt++; if (bus4.I_RVALID !== 1'b0 || bus4.I_RDATA !== 32'd0)
      $display("[TB] FAIL midrst_drop_c1: got v=%b d=%h expected 0 0", bus4.I_RVALID, bus4.I_RDATA); else pass_cnt++;
    tick();
    RST = 1'b0;
    #1;
    chk_cnt++; if (bus4.I_RVALID !== 1'b0) $display("[TB] FAIL midrst_drop_c2: got %b expected 0", bus4.I_RVALID); else pass_cnt++;
    chk_cnt++; if (bus4.CONFLICT_CNT !== 32'd0) $display("[TB] FAIL midrst_conflict_cnt: got %0d expected 0", bus4.CONFLICT_CNT); else pass_cnt++;
  endtask

  task automatic test_reset_wait_cnt();
    logic [4:0] exp_i;
    exp_i = 5'b10000;
    tick();
    bus4.I_REQ = 1'b1;
    bus4.D_REQ = 1'b1;
    bus4.D_WE  = 1'b0;
    #1;
    chk_cnt++; if (bus4.D_GNT !== 1'b1) $display("[TB] FAIL waitrst_pre0: got %b expected 1", bus4.D_GNT); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (bus4.D_GNT !== 1'b1) $display("[TB] FAIL waitrst_pre1: got %b expected 1", bus4.D_GNT); else pass_cnt++;
    tick();
    RST = 1'b1;
    #1;
    chk_cnt++; if (bus4.I_GNT !== 1'b0 || bus4.D_GNT !== 1'b0 || bus4.M_EN !== 1'b0 || bus4.STALL_IF !== 1'b1)
      $display("[TB] FAIL waitrst_in_reset: got i=%b d=%b en=%b stall=%b expected 0 0 0 1",
               bus4.I_GNT, bus4.D_GNT, bus4.M_EN, bus4.STALL_IF); else pass_cnt++;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk_cnt++; if (bus4.I_GNT !== exp_i[k] || bus4.D_GNT !== ~exp_i[k])
        $display("[TB] FAIL waitrst_grant c%0d: got i=%b d=%b expected i=%b d=%b", k, bus4.I_GNT, bus4.D_GNT, exp_i[k], ~exp_i[k]); else pass_cnt++;
    end
    tick();
    bus4.I_REQ = 1'b0;
    bus4.D_REQ = 1'b0;
    #1;
    chk_cnt++; if (bus4.CONFLICT_CNT !== 32'd5) $display("[TB] FAIL waitrst_conflict_cnt: got %0d expected 5", bus4.CONFLICT_CNT); else pass_cnt++;
  endtask

  task automatic test_max_wait_zero();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        bus0.I_REQ  = 1'b1;
        bus0.I_ADDR = 32'h0000_0040;
        bus0.D_REQ  = 1'b1;
        bus0.D_ADDR = 32'h0000_0080;
      end
      #1;
      chk_cnt++; if (bus0.I_GNT !== 1'b1 || bus0.D_GNT !== 1'b0)
        $display("[TB] FAIL mw0_grant c%0d: got i=%b d=%b expected i=1 d=0", k, bus0.I_GNT, bus0.D_GNT); else pass_cnt++;
    end
    tick();
    bus0.I_REQ = 1'b0;
    bus0.D_REQ = 1'b0;
    #1;
    chk_cnt++; if (bus0.CONFLICT_CNT !== 32'd3) $display("[TB] FAIL mw0_conflict_cnt: got %0d expected 3", bus0.CONFLICT_CNT); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    RST      = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_conflict();
    test_back_to_back();
    test_store();
    test_reset_mid_read();
    test_reset_wait_cnt();
    test_max_wait_zero();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
